bcd_converter: RTL and testbench
================================

# bcd_converter

Sequential binary-to-BCD converter (shift-and-add-3) that turns a WIDTH-bit unsigned value, such as a register or PC value from the multicycle processor, into DIGITS packed BCD nibbles. It sits directly upstream of the board's seven-segment `displayDecoder` instances: each output nibble feeds one decoder's 4-bit `entrada`, so the display shows decimal rather than hex. The converter uses a start/busy/done handshake and holds its last result stable between conversions.

## Interface
- WIDTH, 16, input width in bits; legal range 4..32.
- DIGITS, 5, number of BCD digits produced.
  - DIGITS must satisfy 10^DIGITS > 2^WIDTH - 1.
  - An illegal combination fails at elaboration.
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  request a conversion; sampled only when busy=0.
- entrada  input  WIDTH  unsigned binary value; captured on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse marking that bcd has just been updated.
- bcd  output  4*DIGITS  packed result.
  - bcd[4i+3:4i] is decimal digit i; i=0 is the least significant digit.
  - Each nibble is always in 0..9.

## Operation
- Two states: IDLE and CONV.
- Internal registers:
  - shift register of WIDTH bits (the binary operand).
  - working BCD register of 4*DIGITS bits.
  - iteration counter, sized for 0..WIDTH.
  - output register that drives bcd.
- IDLE with start=1:
  - Capture entrada into the shift register and clear the working BCD register.
  - Load the counter with WIDTH and go to CONV.
- IDLE with start=0: hold all registers.
- CONV, once per cycle:
  - For each working nibble, if the nibble is >= 5, add 3. This is combinational and happens in the same cycle as the shift.
  - Shift {working BCD, shift register} left by 1. The shift-register MSB enters BCD bit 0.
  - Decrement the counter.
- CONV, on the iteration where the counter is 1:
  - Write the post-shift working value into the bcd output register.
  - Assert done for the following cycle and return to IDLE.
- start while busy=1 is ignored and not queued. Changes on entrada after capture have no effect.
- bcd changes only on a completion edge or on reset. Between those it holds the previous result, so the displays never show partial values.
- The add-3 step is applied before the shift on every iteration, including the first. This is harmless because the working register is 0 on the first iteration.
- Arithmetic is unsigned only; there is no sign handling. The top-digit carry cannot be lost given the DIGITS constraint.

## Timing
- Reset values:
  - busy=0, done=0, bcd=0.
  - State IDLE, counter 0, shift and working registers 0.
- reset=1 takes priority over everything, including mid-conversion.
  - A conversion in progress is aborted and bcd is cleared to 0.
  - No done is produced for the aborted conversion.
- Start accepted at edge k:
  - busy=1 after edges k .. k+WIDTH-1.
  - Iterations execute at edges k+1 .. k+WIDTH.
- At edge k+WIDTH:
  - bcd is updated, done=1, busy=0.
  - done=1 lasts exactly one cycle and is cleared at edge k+WIDTH+1.
- Latency from the start edge to a valid bcd is WIDTH cycles; done is coincident with the new bcd.
- Back-to-back operation:
  - start=1 during the done cycle is accepted, because the state is IDLE.
  - Minimum start-to-start period is WIDTH+1 cycles.
- If start=1 and reset=1 arrive on the same edge, reset wins and nothing is captured.

## Test plan
- Zero value. Reset, then start with entrada=0 → done exactly 16 cycles after the start edge, bcd=20'h00000, busy high for 16 cycles.
- Full scale. entrada=16'hFFFF (65535) → bcd=20'h65535, one-cycle done pulse. Also entrada=1234 → bcd=20'h01234.
- Start while busy. Start with 4321; 5 cycles later pulse start with entrada=9999 → only one done, bcd=20'h04321. Changing entrada during CONV also has no effect.
- Reset mid-conversion. Complete a conversion of 777, then start with 500 and assert reset 8 cycles in → bcd=0, busy=0, done never asserts. A following start with 42 gives bcd=20'h00042.
- Back-to-back conversions. Start with 100, then assert start with 250 in the done cycle → second done exactly 17 cycles after the first. bcd sequence is 20'h00100 then 20'h00250, each held stable until its replacement.
- Parameter variant. WIDTH=8, DIGITS=3: entrada=255 → bcd=12'h255 after 8 cycles; entrada=9 → 12'h009.

Source files
------------

// File: rtl/bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_converter
//  Function : Sequential shift-and-add-3 binary to packed BCD converter with a
//             start/busy/done handshake and a result held between conversions.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      entrada,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    function automatic bit digits_fit(input int w, input int d);
        longint unsigned lim;
        longint unsigned p;
        lim = (64'd1 << w) - 64'd1;
        p   = 64'd1;
        for (int i = 0; i < d; i++) begin
            if (p <= lim) p = p * 64'd10;
        end
        return p > lim;
    endfunction

    if (WIDTH < 4 || WIDTH > 32 || !digits_fit(WIDTH, DIGITS)) begin : g_bad_params
        $error("bcd_converter: illegal WIDTH/DIGITS combination");
    end

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t                 state;
    logic [WIDTH-1:0]       shift_q;
    logic [4*DIGITS-1:0]    work_q;
    logic [CNT_W-1:0]       count_q;
    logic [4*DIGITS-2:0]    adjusted;
    logic [4*DIGITS-1:0]    next_work;

    // The top nibble's carry bit is shifted out, and cannot be set given the
    // DIGITS constraint, so only its low three bits are kept.
    genvar g;
    for (g = 0; g < DIGITS - 1; g++) begin : g_adj
        assign adjusted[4*g +: 4] = add3(work_q[4*g +: 4]);
    end
    assign adjusted[4*DIGITS-2 -: 3] = 3'(add3(work_q[4*DIGITS-1 -: 4]));

    assign next_work = {adjusted, shift_q[WIDTH-1]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            shift_q <= '0;
            work_q  <= '0;
            count_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_q <= entrada;
                        work_q  <= '0;
                        count_q <= CNT_W'(WIDTH);
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    shift_q <= shift_q << 1;
                    work_q  <= next_work;
                    count_q <= count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        bcd   <= next_work;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_converter
//  Function : Directed and random checks of bcd_converter against a decimal
//             digit model (16-bit/5-digit and 8-bit/3-digit instances).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_converter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] entrada = '0;
    logic        busy;
    logic        done;
    logic [19:0] bcd;

    logic        start8 = 1'b0;
    logic [7:0]  entrada8 = '0;
    logic        busy8;
    logic        done8;
    logic [11:0] bcd8;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
        .clock(clock), .reset(reset), .start(start), .entrada(entrada),
        .busy(busy), .done(done), .bcd(bcd)
    );

    bcd_converter #(.WIDTH(8), .DIGITS(3)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .entrada(entrada8),
        .busy(busy8), .done(done8), .bcd(bcd8)
    );

    // Decimal digits by repeated division, independent of the add-3 algorithm.
    function automatic logic [63:0] ref_bcd(input int unsigned v, input int ndig);
        logic [63:0] r;
        int unsigned d;
        r = '0;
        d = v;
        for (int i = 0; i < ndig; i++) begin
            r[4*i +: 4] = 4'(d % 10);
            d = d / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Full conversion on the 16-bit instance with latency, busy and pulse checks.
    task automatic conv16(input logic [15:0] v, input string tag);
        int lat;
        int busy_cnt;
        start   = 1'b1;
        entrada = v;
        tick();
        start    = 1'b0;
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_cnt++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd16);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd16);
        check({tag, "_bcd"}, 64'(bcd), ref_bcd(v, 5));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        tick();
        check({tag, "_done_pulse_end"}, 64'(done), 64'd0);
        check({tag, "_bcd_hold"}, 64'(bcd), ref_bcd(v, 5));
    endtask

    task automatic conv8(input logic [7:0] v, input string tag);
        int lat;
        start8   = 1'b1;
        entrada8 = v;
        tick();
        start8 = 1'b0;
        lat    = 0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (done8) begin
                lat = n;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'd8);
        check({tag, "_bcd"}, 64'(bcd8), ref_bcd(32'(v), 3));
        tick();
        check({tag, "_done_pulse_end"}, 64'(done8), 64'd0);
    endtask

    initial begin
        int dones;
        int gap;
        bit stable;
        logic [15:0] rv;

        tick();
        tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_bcd", 64'(bcd), 64'd0);
        reset = 1'b0;
        tick();

        conv16(16'd0, "zero");
        conv16(16'hFFFF, "full_scale");
        conv16(16'd1234, "v1234");
        for (int i = 0; i < 12; i++) begin
            rv = 16'($urandom);
            conv16(rv, "random");
        end

        // Start while busy is ignored; entrada changes during CONV are ignored.
        start   = 1'b1;
        entrada = 16'd4321;
        tick();
        start = 1'b0;
        dones = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n == 5) begin
                start   = 1'b1;
                entrada = 16'd9999;
            end else begin
                start = 1'b0;
            end
            if (n == 8) entrada = 16'd1111;
            tick();
            if (done) dones++;
        end
        start = 1'b0;
        check("busy_ignore_dones", 64'(dones), 64'd1);
        check("busy_ignore_bcd", 64'(bcd), ref_bcd(4321, 5));

        // Reset mid-conversion aborts and clears bcd.
        conv16(16'd777, "v777");
        start   = 1'b1;
        entrada = 16'd500;
        tick();
        start = 1'b0;
        for (int n = 0; n < 7; n++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_bcd", 64'(bcd), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        dones = 0;
        for (int n = 0; n < 25; n++) begin
            tick();
            if (done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        conv16(16'd42, "after_abort");

        // Start and reset on the same edge: nothing is captured.
        start   = 1'b1;
        reset   = 1'b1;
        entrada = 16'd321;
        tick();
        start = 1'b0;
        reset = 1'b0;
        check("start_reset_busy", 64'(busy), 64'd0);
        tick();
        check("start_reset_idle", 64'(busy), 64'd0);

        // Back-to-back: second start issued in the done cycle.
        start   = 1'b1;
        entrada = 16'd100;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (done) break;
        end
        check("b2b_first_done", 64'(done), 64'd1);
        check("b2b_first_bcd", 64'(bcd), ref_bcd(100, 5));
        start   = 1'b1;
        entrada = 16'd250;
        gap     = 0;
        stable  = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            start = 1'b0;
            if (done) begin
                gap = n;
                break;
            end
            if (bcd !== 20'h00100) stable = 1'b0;
        end
        check("b2b_gap", 64'(gap), 64'd17);
        check("b2b_first_held", 64'(stable), 64'd1);
        check("b2b_second_bcd", 64'(bcd), ref_bcd(250, 5));

        conv8(8'd255, "w8_255");
        conv8(8'd9, "w8_9");
        for (int i = 0; i < 4; i++) conv8(8'($urandom), "w8_random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
